// File: rtl/freq_div_mon_pkg.sv
// Shared state encoding and default sizing for the divided-clock monitor.
package freq_div_mon_pkg;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_LOCK_COUNT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// Registers the divided clock and flags the cycle in which it goes high.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic div_in,
    output logic rise
);

    logic div_d_q;
    logic div_d_d;

    always_comb begin
        div_d_d = div_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_d_q <= 1'b0;
        end else begin
            div_d_q <= div_d_d;
        end
    end

    assign rise = div_in & ~div_d_q;

endmodule

// File: rtl/freq_div_monitor.sv
// Measures period and high time of a divided clock against expected values,
// reporting per-measurement errors, stuck input and a lock level.
module freq_div_monitor
    import freq_div_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] exp_high,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             period_err,
    output logic             stuck,
    output logic             lock
);

    localparam int                 MATCH_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_COUNT);

    logic rise;

    rise_detect u_rise_detect (
        .clk    (clk),
        .rst    (rst),
        .div_in (div_in),
        .rise   (rise)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               meas_valid_q, meas_valid_d;
    logic               period_err_q, period_err_d;
    logic               stuck_q, stuck_d;
    logic               lock_q, lock_d;
    logic               meas_ok;

    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        hcnt_d       = hcnt_q;
        period_d     = period_q;
        high_d       = high_q;
        match_d      = match_q;
        meas_valid_d = 1'b0;
        period_err_d = 1'b0;
        stuck_d      = 1'b0;
        meas_ok      = (pcnt_q == exp_period) && (hcnt_q == exp_high);

        if (!en) begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
            hcnt_d  = '0;
            match_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_MEASURE;
                        pcnt_d  = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        pcnt_d       = CNT_ONE;
                        hcnt_d       = CNT_ONE;
                        period_d     = pcnt_q;
                        high_d       = hcnt_q;
                        meas_valid_d = 1'b1;
                        period_err_d = !meas_ok;
                        if (!meas_ok) begin
                            match_d = '0;
                        end else if (match_q != MATCH_FULL) begin
                            match_d = match_q + 1'b1;
                        end
                    // Fire as pcnt hits its ceiling so the pulse lands 2^CNT_W-1 cycles after the rise cycle.
                    end else if (pcnt_q >= CNT_MAX - 1'b1) begin
                        pcnt_d  = CNT_MAX;
                        stuck_d = 1'b1;
                        match_d = '0;
                        state_d = ST_ARM;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                        if (div_in && (hcnt_q != CNT_MAX)) begin
                            hcnt_d = hcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        lock_d = (match_d == MATCH_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pcnt_q       <= '0;
            hcnt_q       <= '0;
            period_q     <= '0;
            high_q       <= '0;
            match_q      <= '0;
            meas_valid_q <= 1'b0;
            period_err_q <= 1'b0;
            stuck_q      <= 1'b0;
            lock_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            hcnt_q       <= hcnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            match_q      <= match_d;
            meas_valid_q <= meas_valid_d;
            period_err_q <= period_err_d;
            stuck_q      <= stuck_d;
            lock_q       <= lock_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = meas_valid_q;
    assign period_err = period_err_q;
    assign stuck      = stuck_q;
    assign lock       = lock_q;

endmodule

// File: tb/tb_freq_div_monitor.sv
// Scoreboard bench for freq_div_monitor: stimulus queues expected measurements
// and stuck events, a negedge monitor pops and compares them.
module tb_freq_div_monitor;

    localparam int CNT_W = 8;

    typedef struct {
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] h;
        logic             err;
        logic             lk;
    } meas_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             div_in;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] exp_high;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             period_err;
    logic             stuck;
    logic             lock;

    int    n_checks      = 0;
    int    n_pass        = 0;
    int    cyc           = 0;
    int    last_rise_cyc = 0;
    int    stuck_seen    = 0;
    meas_t exp_q[$];
    int    stuck_q[$];
    meas_t e;
    int    exp_c;

    freq_div_monitor #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_in     (div_in),
        .exp_period (exp_period),
        .exp_high   (exp_high),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .period_err (period_err),
        .stuck      (stuck),
        .lock       (lock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    task automatic note_fail(input string name, input int act, input int req);
        n_checks++;
        $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One divided-clock period: hi cycles high starting with the rise, then lo cycles low.
    task automatic run_period(input int hi, input int lo, input bit push,
                              input int ep, input int eh, input bit eerr, input bit elk);
        meas_t m;
        if (push) begin
            m.p = CNT_W'(ep);
            m.h = CNT_W'(eh);
            m.err = eerr;
            m.lk = elk;
            exp_q.push_back(m);
        end
        div_in = 1'b1;
        tick();
        last_rise_cyc = cyc;
        repeat (hi - 1) tick();
        div_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic wait_stuck;
        int seen0 = stuck_seen;
        int i = 0;
        while (stuck_seen == seen0 && i < 400) begin
            tick();
            i++;
        end
        if (stuck_seen == seen0) note_fail("stuck_timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_high_time"}, int'(high_time), 0);
        chk({tag, "_meas_valid"}, int'(meas_valid), 0);
        chk({tag, "_period_err"}, int'(period_err), 0);
        chk({tag, "_stuck"}, int'(stuck), 0);
        chk({tag, "_lock"}, int'(lock), 0);
    endtask

    always @(negedge clk) begin
        if (meas_valid) begin
            if (exp_q.size() == 0) begin
                note_fail("meas_unexpected", int'(period), -1);
            end else begin
                e = exp_q.pop_front();
                chk("meas_period", int'(period), int'(e.p));
                chk("meas_high_time", int'(high_time), int'(e.h));
                chk("meas_period_err", int'(period_err), int'(e.err));
                chk("meas_lock", int'(lock), int'(e.lk));
            end
        end else if (period_err) begin
            note_fail("err_without_valid", 1, 0);
        end
        if (stuck) begin
            stuck_seen++;
            if (stuck_q.size() == 0) begin
                note_fail("stuck_unexpected", cyc, -1);
            end else begin
                exp_c = stuck_q.pop_front();
                chk("stuck_cycle", cyc, exp_c);
                chk("stuck_lock", int'(lock), 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        en = 1'b0;
        div_in = 1'b0;
        exp_period = 8'd4;
        exp_high = 8'd2;
        repeat (3) tick();
        check_zero("reset");

        // Divide-by-4, lock on the fourth measurement.
        rst = 1'b0;
        en = 1'b1;
        tick();
        run_period(2, 2, 0, 0, 0, 0, 0);
        repeat (3) run_period(2, 2, 1, 4, 2, 0, 0);
        repeat (2) run_period(2, 2, 1, 4, 2, 0, 1);

        // en dropped on a rise: no measurement, lock clears, results hold.
        en = 1'b0;
        div_in = 1'b1;
        tick();
        @(negedge clk);
        chk("endrop_lock", int'(lock), 0);
        chk("endrop_period", int'(period), 4);
        chk("endrop_high_time", int'(high_time), 2);
        div_in = 1'b0;
        tick();

        // Divide-by-3, then a changed expectation forces an error.
        exp_period = 8'd3;
        exp_high = 8'd1;
        en = 1'b1;
        tick();
        run_period(1, 2, 0, 0, 0, 0, 0);
        repeat (3) run_period(1, 2, 1, 3, 1, 0, 0);
        run_period(1, 2, 1, 3, 1, 0, 1);
        exp_period = 8'd4;
        run_period(1, 2, 1, 3, 1, 1, 0);
        exp_period = 8'd3;
        repeat (3) run_period(1, 2, 1, 3, 1, 0, 0);
        run_period(1, 2, 1, 3, 1, 0, 1);

        // div_in stuck low after lock.
        stuck_q.push_back(last_rise_cyc + 254);
        wait_stuck();

        // Resume: one arming rise plus four measurements to relock.
        run_period(1, 2, 0, 0, 0, 0, 0);
        repeat (3) run_period(1, 2, 1, 3, 1, 0, 0);
        run_period(1, 2, 1, 3, 1, 0, 1);

        // div_in stuck high: the final rise measures normally, then stuck.
        exp_q.push_back('{8'd3, 8'd1, 1'b0, 1'b1});
        div_in = 1'b1;
        tick();
        last_rise_cyc = cyc;
        stuck_q.push_back(last_rise_cyc + 254);
        wait_stuck();
        div_in = 1'b0;
        repeat (2) tick();

        // Reset in the middle of a period.
        exp_period = 8'd4;
        exp_high = 8'd2;
        run_period(2, 2, 0, 0, 0, 0, 0);
        repeat (2) run_period(2, 2, 1, 4, 2, 0, 0);
        exp_q.push_back('{8'd4, 8'd2, 1'b0, 1'b0});
        div_in = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check_zero("midreset");
        rst = 1'b0;
        div_in = 1'b0;
        tick();
        run_period(2, 2, 0, 0, 0, 0, 0);
        repeat (2) run_period(2, 2, 1, 4, 2, 0, 0);

        repeat (4) tick();
        chk("meas_queue_drained", exp_q.size(), 0);
        chk("stuck_queue_drained", stuck_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/freq_div_monitor.md
FREQ_DIV_MONITOR -- requirements
Module: freq_div_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of period/high-time counters and expected values.
REQ-002 SHALL have parameter LOCK_COUNT, default 4: consecutive matching periods required to assert lock.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1: 1 = monitor running, 0 = idle.
REQ-006 SHALL have port div_in, input, 1: divided-clock signal from the frequency divider, synchronous to clk.
REQ-007 SHALL have port exp_period, input, CNT_W: expected clk cycles between div_in rising edges (e.g. 4 for divide-by-4).
REQ-008 SHALL have port exp_high, input, CNT_W: expected clk cycles div_in is high per period.
REQ-009 SHALL have port period, output, CNT_W: last measured period.
REQ-010 SHALL have port high_time, output, CNT_W: last measured high time.
REQ-011 SHALL have port meas_valid, output, 1: one-cycle pulse when period/high_time update.
REQ-012 SHALL have port period_err, output, 1: one-cycle pulse on mismatch, coincident with meas_valid.
REQ-013 SHALL have port stuck, output, 1: one-cycle pulse when no rising edge occurs within 2^CNT_W-1 cycles.
REQ-014 SHALL have port lock, output, 1: level; divider output matches expectation.

Function
REQ-015 SHALL register div_in into div_d; rise = div_in & ~div_d.
REQ-016 SHALL implement states IDLE, ARM, MEASURE.
REQ-017 IDLE -> ARM when en=1; ARM -> MEASURE on first rise (no measurement emitted); any state -> IDLE on next cycle when en=0.
REQ-018 In MEASURE, pcnt SHALL load 1 on rise, else increment, saturating at 2^CNT_W-1.
REQ-019 hcnt SHALL load 1 on rise, else increment when div_in=1, saturating.
REQ-020 On rise in MEASURE: period<=pcnt, high_time<=hcnt, meas_valid=1 in the following cycle (latency 1 from the rise cycle).
REQ-021 Divide-by-4 input (high 2, low 2) SHALL yield period=4, high_time=2; divide-by-3 (high 1, low 2) SHALL yield period=3, high_time=1.
REQ-022 period_err SHALL pulse with meas_valid when period!=exp_period or high_time!=exp_high, using exp_* sampled in the rise cycle.
REQ-023 match counter SHALL increment on each matching measurement (saturate at LOCK_COUNT), clear on mismatch; lock=1 while count==LOCK_COUNT.
REQ-024 If pcnt saturates without rise: stuck pulses once, lock and match counter clear, state -> ARM.
REQ-025 en=0 coincident with rise: en wins, no meas_valid, no update.
REQ-026 In IDLE: lock=0, counters cleared, period/high_time hold last values.
REQ-027 div_in constant high or low SHALL both be handled by REQ-024 (no false measurement).

Reset
REQ-028 On rst: state=IDLE, div_d=0, pcnt=hcnt=0, match count=0, period=high_time=0, meas_valid=period_err=stuck=lock=0.
REQ-029 rst SHALL override en and div_in in the same cycle; mid-measurement reset discards partial counts.

Structure
REQ-030 Package freq_div_mon_pkg SHALL hold the state enum and default CNT_W/LOCK_COUNT constants.
REQ-031 One sub-module, rise_detect (div_in register + rise pulse), SHALL be instantiated; the rest is flat.

Verification
REQ-032 Divide-by-4 stimulus, exp 4/2, en=1: first meas_valid after second rise, period=4, high_time=2, no err; lock=1 after 4th measurement.
REQ-033 Divide-by-3 stimulus, exp 3/1: period=3, high_time=1, lock after 4 measurements; then exp_period=4 -> period_err pulse, lock drops next cycle.
REQ-034 div_in held 0 after lock, CNT_W=8: stuck pulses 255 cycles after last rise, lock=0, state ARM; resumed clock relocks after 1+4 rises.
REQ-035 en dropped in the same cycle as a rise: no meas_valid, lock=0, period holds prior value (4).
REQ-036 rst asserted mid-period: all outputs 0 next cycle; after release with en=1, first measurement only after two rises.
